// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXE/MEM/WB controller for a multi-cycle MIPS core; MC_PERF_CNT_EN adds cycle_cnt/instr_cnt
module multi_cycle_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ALUflag_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSel,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] A3Sel,
  output logic [1:0] WDSel,
  output logic [2:0] ALUOp,
  output logic       ALUBSel,
  output logic       EXTOp,
  output logic [1:0] DMOp,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);
  localparam logic [1:0] A3SEL_RT = 2'd0, A3SEL_RD = 2'd1, A3SEL_RA = 2'd2;
  localparam logic [1:0] WDSEL_ALU = 2'd0, WDSEL_DMRD = 2'd1, WDSEL_PCA4 = 2'd2;
  localparam logic [1:0] PCSEL_PCA4 = 2'd0, PCSEL_BR = 2'd1, PCSEL_J = 2'd2, PCSEL_JR = 2'd3;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;
  localparam logic [1:0] DM_WORD = 2'd1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic timeout;
  wire is_r   = opcode == 6'b000000;
  wire is_add = is_r && funct == 6'b100000;
  wire is_sub = is_r && funct == 6'b100010;
  wire is_jr  = is_r && funct == 6'b001000;
  wire is_ori = opcode == 6'b001101;
  wire is_lw  = opcode == 6'b100011;
  wire is_sw  = opcode == 6'b101011;
  wire is_beq = opcode == 6'b000100;
  wire is_lui = opcode == 6'b001111;
  wire is_jal = opcode == 6'b000011;
  wire is_j   = opcode == 6'b000010;
  wire is_jmp = is_j || is_jal || is_jr;
  wire legal  = is_add || is_sub || is_jr || is_ori || is_lw || is_sw || is_beq || is_lui || is_jal || is_j;
  assign state   = state_q;
  assign DMOp    = (is_lw || is_sw) ? DM_WORD : 2'd0;
  assign timeout = (state_q == FETCH || state_q == MEM) && !mem_ready && wait_q == CW'(TIMEOUT_CYC - 1);
  // counter only runs while a memory wait is still pending; any state change or abort clears it
  assign wait_d  = (mem_req && !mem_ready && !timeout) ? wait_q + CW'(1) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSel    = PCSEL_PCA4;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    A3Sel    = A3SEL_RT;
    WDSel    = WDSEL_ALU;
    ALUOp    = ALU_ADD;
    ALUBSel  = 1'b0;
    EXTOp    = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (state_q == EXE || state_q == MEM || state_q == WB) begin
      ALUOp   = (is_sub || is_beq) ? ALU_SUB : is_ori ? ALU_OR : is_lui ? ALU_LUI : ALU_ADD;
      ALUBSel = is_ori || is_lui || is_lw || is_sw;
      EXTOp   = is_lw || is_sw || is_beq;
    end
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
        end
      end
      DECODE: begin
        PCWrite  = is_jmp;
        PCSel    = is_jr ? PCSEL_JR : PCSEL_J;
        RegWrite = is_jal;
        A3Sel    = is_jal ? A3SEL_RA : A3SEL_RT;
        WDSel    = is_jal ? WDSEL_PCA4 : WDSEL_ALU;
        illegal  = !legal;
        state_d  = (is_jmp || !legal) ? FETCH : EXE;
      end
      EXE: begin
        PCWrite = is_beq && ALUflag_zero;
        PCSel   = is_beq ? PCSEL_BR : PCSEL_PCA4;
        state_d = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = is_sw && !timeout;
        if (mem_ready) begin
          state_d = is_sw ? FETCH : WB;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        A3Sel    = is_r ? A3SEL_RD : A3SEL_RT;
        WDSel    = is_lw ? WDSEL_DMRD : WDSEL_ALU;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // async reset lands in FETCH immediately; suppress every side effect until it is released
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end
  end
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_d == FETCH && state_q != FETCH && !bus_err) instr_q <= instr_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed per-scenario checks of the multi-cycle controller state sequence and control outputs
module tb_multi_cycle_ctrl;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_LUI = 6'b001111, OP_JAL = 6'b000011, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_JR = 6'b001000;
  localparam logic [1:0] A3_RT = 2'd0, A3_RD = 2'd1, A3_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_DMRD = 2'd1, WD_PCA4 = 2'd2;
  localparam logic [1:0] PC_A4 = 2'd0, PC_BR = 2'd1, PC_J = 2'd2, PC_JR = 2'd3;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;
  localparam logic [1:0] DM_WORD = 2'd1;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic ALUflag_zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, ALUBSel, EXTOp, illegal, bus_err;
  logic [1:0] PCSel, A3Sel, WDSel, DMOp;
  logic [2:0] ALUOp, state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  int tests = 0, fails = 0;
  logic [10:0] e;
  wire [10:0] ctl = {state, mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, illegal, bus_err};
  always #5 clk = ~clk;
  multi_cycle_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .ALUflag_zero(ALUflag_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSel(PCSel), .RegWrite(RegWrite), .MemWrite(MemWrite), .A3Sel(A3Sel), .WDSel(WDSel),
    .ALUOp(ALUOp), .ALUBSel(ALUBSel), .EXTOp(EXTOp), .DMOp(DMOp), .state(state),
    .illegal(illegal), .bus_err(bus_err)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; funct = fn; ALUflag_zero = z; mem_ready = rdy;
    #1;
  endtask
  task automatic test_reset;
    #1 mem_ready = 1'b1;
    #1;
    e = {3'd0, 8'b10000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL reset_ctl: got %b exp %b", ctl, e); end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
  endtask
  task automatic test_ori;
    step(OP_ORI, 6'h34, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL ori_fetch: got %b exp %b", ctl, e); end
    tests++; if (PCSel !== PC_A4) begin fails++; $display("FAIL ori_fetch_pcsel: got %0d exp %0d", PCSel, PC_A4); end
    step(OP_ORI, 6'h34, 0, 1);
    e = {3'd1, 8'b00000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL ori_decode: got %b exp %b", ctl, e); end
    step(OP_ORI, 6'h34, 0, 1);
    e = {3'd2, 8'b00000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL ori_exe: got %b exp %b", ctl, e); end
    tests++; if ({ALUOp, ALUBSel, EXTOp} !== {ALU_OR, 1'b1, 1'b0}) begin fails++; $display("FAIL ori_exe_alu: got %b exp %b", {ALUOp, ALUBSel, EXTOp}, {ALU_OR, 2'b10}); end
    step(OP_ORI, 6'h34, 0, 1);
    e = {3'd4, 8'b00001000}; tests++; if (ctl !== e) begin fails++; $display("FAIL ori_wb: got %b exp %b", ctl, e); end
    tests++; if ({A3Sel, WDSel, ALUOp, EXTOp} !== {A3_RT, WD_ALU, ALU_OR, 1'b0}) begin fails++; $display("FAIL ori_wb_sel: got %b exp %b", {A3Sel, WDSel, ALUOp, EXTOp}, {A3_RT, WD_ALU, ALU_OR, 1'b0}); end
  endtask
  task automatic test_lw_wait;
    step(OP_LW, 0, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL lw_fetch: got %b exp %b", ctl, e); end
    step(OP_LW, 0, 0, 1);
    step(OP_LW, 0, 0, 1);
    e = {3'd2, 8'b00000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL lw_exe: got %b exp %b", ctl, e); end
    tests++; if ({ALUOp, ALUBSel, EXTOp} !== {ALU_ADD, 1'b1, 1'b1}) begin fails++; $display("FAIL lw_exe_alu: got %b exp %b", {ALUOp, ALUBSel, EXTOp}, {ALU_ADD, 2'b11}); end
    for (int i = 0; i < 4; i++) begin
      step(OP_LW, 0, 0, i == 3);
      e = {3'd3, 8'b11000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL lw_mem%0d: got %b exp %b", i, ctl, e); end
    end
    tests++; if (DMOp !== DM_WORD) begin fails++; $display("FAIL lw_dmop: got %0d exp %0d", DMOp, DM_WORD); end
    step(OP_LW, 0, 0, 1);
    e = {3'd4, 8'b00001000}; tests++; if (ctl !== e) begin fails++; $display("FAIL lw_wb: got %b exp %b", ctl, e); end
    tests++; if ({A3Sel, WDSel} !== {A3_RT, WD_DMRD}) begin fails++; $display("FAIL lw_wb_sel: got %b exp %b", {A3Sel, WDSel}, {A3_RT, WD_DMRD}); end
  endtask
  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      step(OP_BEQ, 0, z[0], 1);
      step(OP_BEQ, 0, z[0], 1);
      e = {3'd1, 8'b00000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL beq%0d_decode: got %b exp %b", z, ctl, e); end
      step(OP_BEQ, 0, z[0], 1);
      e = {3'd2, 3'b000, z[0], 4'b0000}; tests++; if (ctl !== e) begin fails++; $display("FAIL beq%0d_exe: got %b exp %b", z, ctl, e); end
      tests++; if ({PCSel, ALUOp} !== {PC_BR, ALU_SUB}) begin fails++; $display("FAIL beq%0d_sel: got %b exp %b", z, {PCSel, ALUOp}, {PC_BR, ALU_SUB}); end
    end
    step(OP_BEQ, 0, 0, 0);
    e = {3'd0, 8'b10000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL beq_refetch: got %b exp %b", ctl, e); end
  endtask
  task automatic test_jumps;
    step(OP_JAL, 0, 0, 1);
    step(OP_JAL, 0, 0, 1);
    e = {3'd1, 8'b00011000}; tests++; if (ctl !== e) begin fails++; $display("FAIL jal_decode: got %b exp %b", ctl, e); end
    tests++; if ({PCSel, A3Sel, WDSel} !== {PC_J, A3_RA, WD_PCA4}) begin fails++; $display("FAIL jal_sel: got %b exp %b", {PCSel, A3Sel, WDSel}, {PC_J, A3_RA, WD_PCA4}); end
    step(OP_J, 0, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL jal_next_fetch: got %b exp %b", ctl, e); end
    step(OP_J, 0, 0, 1);
    e = {3'd1, 8'b00010000}; tests++; if (ctl !== e) begin fails++; $display("FAIL j_decode: got %b exp %b", ctl, e); end
    tests++; if (PCSel !== PC_J) begin fails++; $display("FAIL j_pcsel: got %0d exp %0d", PCSel, PC_J); end
    step(OP_R, F_JR, 0, 1);
    step(OP_R, F_JR, 0, 1);
    e = {3'd1, 8'b00010000}; tests++; if (ctl !== e) begin fails++; $display("FAIL jr_decode: got %b exp %b", ctl, e); end
    tests++; if (PCSel !== PC_JR) begin fails++; $display("FAIL jr_pcsel: got %0d exp %0d", PCSel, PC_JR); end
  endtask
  task automatic test_illegal_rtype;
    step(6'b111111, 0, 0, 1);
    step(6'b111111, 0, 0, 1);
    e = {3'd1, 8'b00000010}; tests++; if (ctl !== e) begin fails++; $display("FAIL illegal_decode: got %b exp %b", ctl, e); end
    step(OP_R, F_ADD, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL illegal_refetch: got %b exp %b", ctl, e); end
    step(OP_R, F_ADD, 0, 1);
    step(OP_R, F_ADD, 0, 1);
    tests++; if ({state, ALUOp, ALUBSel} !== {3'd2, ALU_ADD, 1'b0}) begin fails++; $display("FAIL add_exe: got %b exp %b", {state, ALUOp, ALUBSel}, {3'd2, ALU_ADD, 1'b0}); end
    step(OP_R, F_ADD, 0, 1);
    e = {3'd4, 8'b00001000}; tests++; if (ctl !== e) begin fails++; $display("FAIL add_wb: got %b exp %b", ctl, e); end
    tests++; if ({A3Sel, WDSel} !== {A3_RD, WD_ALU}) begin fails++; $display("FAIL add_wb_sel: got %b exp %b", {A3Sel, WDSel}, {A3_RD, WD_ALU}); end
    step(OP_R, F_SUB, 0, 1);
    step(OP_R, F_SUB, 0, 1);
    step(OP_R, F_SUB, 0, 1);
    tests++; if ({state, ALUOp} !== {3'd2, ALU_SUB}) begin fails++; $display("FAIL sub_exe: got %b exp %b", {state, ALUOp}, {3'd2, ALU_SUB}); end
    step(OP_R, F_SUB, 0, 1);
    step(OP_LUI, 0, 0, 1);
    step(OP_LUI, 0, 0, 1);
    step(OP_LUI, 0, 0, 1);
    tests++; if ({state, ALUOp, ALUBSel} !== {3'd2, ALU_LUI, 1'b1}) begin fails++; $display("FAIL lui_exe: got %b exp %b", {state, ALUOp, ALUBSel}, {3'd2, ALU_LUI, 1'b1}); end
    step(OP_LUI, 0, 0, 1);
    tests++; if ({state, A3Sel, RegWrite} !== {3'd4, A3_RT, 1'b1}) begin fails++; $display("FAIL lui_wb: got %b exp %b", {state, A3Sel, RegWrite}, {3'd4, A3_RT, 1'b1}); end
  endtask
  task automatic test_timeout;
    for (int i = 0; i < 15; i++) begin
      step(OP_J, 0, 0, 0);
      e = {3'd0, 8'b10000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL to_wait%0d: got %b exp %b", i, ctl, e); end
    end
    step(OP_J, 0, 0, 0);
    e = {3'd0, 8'b10000001}; tests++; if (ctl !== e) begin fails++; $display("FAIL to_buserr: got %b exp %b", ctl, e); end
    step(OP_J, 0, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL to_refetch: got %b exp %b", ctl, e); end
    step(OP_J, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(OP_J, 0, 0, 0);
    step(OP_J, 0, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL to_ready_wins: got %b exp %b", ctl, e); end
    step(OP_J, 0, 0, 1);
    e = {3'd1, 8'b00010000}; tests++; if (ctl !== e) begin fails++; $display("FAIL to_j_decode: got %b exp %b", ctl, e); end
  endtask
  task automatic test_sw_reset;
    step(OP_SW, 0, 0, 1);
    step(OP_SW, 0, 0, 1);
    step(OP_SW, 0, 0, 1);
    step(OP_SW, 0, 0, 0);
    e = {3'd3, 8'b11000100}; tests++; if (ctl !== e) begin fails++; $display("FAIL sw_mem: got %b exp %b", ctl, e); end
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    e = {3'd0, 8'b10000000}; tests++; if (ctl !== e) begin fails++; $display("FAIL sw_reset: got %b exp %b", ctl, e); end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    step(OP_SW, 0, 0, 1);
    e = {3'd0, 8'b10110000}; tests++; if (ctl !== e) begin fails++; $display("FAIL sw_restart: got %b exp %b", ctl, e); end
  endtask
  initial begin
    test_reset;
    test_ori;
    test_lw_wait;
    test_beq;
    test_jumps;
    test_illegal_rtype;
    test_timeout;
    test_sw_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
